r2s_frame_monitor: RTL and testbench
====================================

Name: r2s_frame_monitor

Overview:
- Consumes the 4-sample-per-cycle deserialised row2sync stream and the frame-sync strobe from the I/O deserialiser stage, in the 80 MHz domain.
- Measures the row period in 320 MHz ticks and counts rows per frame.
- Flags period-window, row-count and glitch errors.
- Emits a one-cycle start pulse on a programmed row number; this pulse drives the pattern generator's external start.

Parameters:
CNT_W, 16, width of period measurement and window bounds, in 320 MHz ticks
ROW_W, 10, width of row counters and row compare values
FRAME_W, 16, width of frame counter

Ports:
CLK  in  1  80 MHz sample clock; all logic in this domain
RST_N  in  1  reset, asynchronous, active-low
R2S_DES  in  4  row2sync samples for this cycle; bit0 earliest, bit3 latest
FSYNC_STROBE  in  1  single-cycle frame-start strobe, already synchronous to CLK
EXP_ROWS  in  ROW_W  expected rows per frame
PERIOD_MIN  in  CNT_W  lowest legal row period, ticks
PERIOD_MAX  in  CNT_W  highest legal row period, ticks
TRIG_ROW  in  ROW_W  row index (0-based within frame) that fires START
TRIG_EN  in  1  enables START generation
CLEAR_ERR  in  1  clears sticky error flags
START  out  1  one-cycle trigger pulse
PERIOD_LAST  out  CNT_W  last measured row period
PERIOD_VALID  out  1  one-cycle pulse when PERIOD_LAST updates
ROW_CNT  out  ROW_W  rows seen so far in current frame
ROWS_LAST_FRAME  out  ROW_W  row count of last completed frame
FRAME_CNT  out  FRAME_W  completed frames, wraps
ERR_PERIOD  out  1  sticky: a period was outside [PERIOD_MIN, PERIOD_MAX]
ERR_ROWS  out  1  sticky: a completed frame had ROWS_LAST_FRAME != EXP_ROWS
ERR_GLITCH  out  1  sticky: more than one rising edge within one cycle window

Behaviour:
- Reset: all outputs and internal state to 0. Internal state: edge history, since counter, first_edge and first_frame flags.
- Edge detection: the 5-bit vector {R2S_DES, prev_bit3} is scanned for 0->1 transitions.
  - p = earliest sample index (0..3) at which a rising edge occurs. A rising edge at sample 0 is judged against the previous cycle's bit3.
  - Two or more edges in one window: set ERR_GLITCH; only the earliest edge is used, so at most one row per cycle.
- Period, with "since" = saturating tick count from the last edge to the start of the current window:
  - Cycle with no edge: since <= sat(since + 4).
  - Edge at p: period = sat(since + p), then since <= 4 - p.
  - sat clamps at 2^CNT_W - 1.
  - First edge after reset produces no period; it only arms measurement.
  - Later edges register PERIOD_LAST and pulse PERIOD_VALID one cycle after the input cycle.
  - ERR_PERIOD is set in that same cycle if period < PERIOD_MIN or period > PERIOD_MAX.
- Row counting:
  - Each edge increments ROW_CNT, saturating at all-ones.
  - START fires one cycle after the edge cycle when TRIG_EN=1 and the pre-increment ROW_CNT == TRIG_ROW. Row 0 is the first edge after FSYNC.
- Frame boundary (FSYNC_STROBE=1):
  - ROWS_LAST_FRAME <= ROW_CNT and FRAME_CNT++ (wraps).
  - ROW_CNT <= 1 if an edge is in the same cycle, else 0. The edge belongs to the new frame, is row 0, and may fire START for TRIG_ROW=0.
  - ERR_ROWS is evaluated only from the second FSYNC after reset. The first frame is partial.
- FSYNC does not reset the period measurement.
- CLEAR_ERR clears all three sticky flags. If an error event occurs in the same cycle, set wins.
- Outputs are registered; worst-case latency from input to any output is 1 cycle.
- Reset asserted mid-frame returns everything to the reset state immediately; no START is emitted until a new edge arrives after deassert.

Decomposition:
- A shared package holds:
  - TICKS_PER_CYCLE = 4
  - the sample-order convention (bit0 earliest)
  - the error-flag bit indices
- One natural sub-module, r2s_edge_detect. It is combinational with a registered prev_bit3 and outputs edge, p[1:0] and multi.
- Counters, window checks and trigger logic stay in the top.

Test Plan:
- Steady edges every 77 ticks (pattern shifting by p), PERIOD_MIN=70, PERIOD_MAX=80 -> PERIOD_LAST=77 on each PERIOD_VALID, no errors, first edge gives no PERIOD_VALID.
- Edge at p=3 then next edge 5 cycles later at p=0 -> period = 4-3 + 4*4 + 0 = 17.
- FSYNC every 8 rows, EXP_ROWS=8, then a frame with 7 rows -> ERR_ROWS set only after the short frame (not after the first partial frame), ROWS_LAST_FRAME=7.
- TRIG_ROW=3, TRIG_EN=1 -> exactly one START per frame, 1 cycle after the 4th edge. With FSYNC and edge coincident and TRIG_ROW=0 -> START next cycle, ROW_CNT=1.
- R2S_DES=4'b0101 with prev_bit3=0 -> ERR_GLITCH=1, ROW_CNT +1 only, p=0. CLEAR_ERR pulse without a new event -> flag 0.
- No edges for 20000 cycles with CNT_W=16 -> next period = 65535 and ERR_PERIOD=1. RST_N pulsed low mid-frame -> all outputs 0 asynchronously.

Source files
------------

// File: rtl/r2s_frame_monitor_pkg.sv
// Shared constants for the row2sync frame monitor: sample ordering, tick scale, error-flag layout.
package r2s_frame_monitor_pkg;

  // Each 80 MHz cycle carries four 320 MHz samples; bit 0 is the earliest.
  localparam int unsigned TICKS_PER_CYCLE = 4;
  localparam int unsigned SAMPLE_FIRST    = 0;
  localparam int unsigned SAMPLE_LAST     = TICKS_PER_CYCLE - 1;

  localparam int unsigned ERR_W          = 3;
  localparam int unsigned ERR_PERIOD_BIT = 0;
  localparam int unsigned ERR_ROWS_BIT   = 1;
  localparam int unsigned ERR_GLITCH_BIT = 2;

  // Index of the earliest set bit; 0 when none is set.
  function automatic logic [1:0] first_rise(input logic [TICKS_PER_CYCLE-1:0] rise);
    first_rise = 2'd0;
    for (int i = TICKS_PER_CYCLE - 1; i >= 0; i--) begin
      if (rise[i]) first_rise = 2'(i);
    end
  endfunction

endpackage

// File: rtl/r2s_edge_detect.sv
// Finds 0->1 transitions across one 4-sample window, using the previous window's last sample.
module r2s_edge_detect
  import r2s_frame_monitor_pkg::*;
(
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [TICKS_PER_CYCLE-1:0] i_des,
  output logic                       o_edge,
  output logic [1:0]                 o_p,
  output logic                       o_multi
);

  logic                       r_prev_bit3;
  logic [TICKS_PER_CYCLE-1:0] w_rise;
  logic [TICKS_PER_CYCLE-1:0] w_rise_m1;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_prev_bit3 <= 1'b0;
    end else begin
      r_prev_bit3 <= i_des[SAMPLE_LAST];
    end
  end

  always_comb begin
    w_rise    = i_des & ~{i_des[SAMPLE_LAST-1:SAMPLE_FIRST], r_prev_bit3};
    w_rise_m1 = w_rise - TICKS_PER_CYCLE'(1);
    o_edge    = |w_rise;
    o_p       = first_rise(w_rise);
    // More than one bit set <=> clearing the lowest set bit leaves something.
    o_multi   = (w_rise & w_rise_m1) != '0;
  end

endmodule

// File: rtl/r2s_frame_monitor.sv
// Row-period / rows-per-frame monitor on the deserialised row2sync stream, with a row-indexed
// start trigger for the pattern generator.
module r2s_frame_monitor
  import r2s_frame_monitor_pkg::*;
#(
  parameter int unsigned CNT_W   = 16,
  parameter int unsigned ROW_W   = 10,
  parameter int unsigned FRAME_W = 16
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic [TICKS_PER_CYCLE-1:0] i_r2s_des,
  input  logic                       i_fsync_strobe,
  input  logic [ROW_W-1:0]           i_exp_rows,
  input  logic [CNT_W-1:0]           i_period_min,
  input  logic [CNT_W-1:0]           i_period_max,
  input  logic [ROW_W-1:0]           i_trig_row,
  input  logic                       i_trig_en,
  input  logic                       i_clear_err,
  output logic                       o_start,
  output logic [CNT_W-1:0]           o_period_last,
  output logic                       o_period_valid,
  output logic [ROW_W-1:0]           o_row_cnt,
  output logic [ROW_W-1:0]           o_rows_last_frame,
  output logic [FRAME_W-1:0]         o_frame_cnt,
  output logic                       o_err_period,
  output logic                       o_err_rows,
  output logic                       o_err_glitch
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [ROW_W-1:0] ROW_MAX = '1;

  logic             w_edge;
  logic [1:0]       w_p;
  logic             w_multi;

  logic [CNT_W-1:0]   r_since;
  logic               r_armed;
  logic               r_fsync_seen;
  logic               r_start;
  logic [CNT_W-1:0]   r_period_last;
  logic               r_period_valid;
  logic [ROW_W-1:0]   r_row_cnt;
  logic [ROW_W-1:0]   r_rows_last;
  logic [FRAME_W-1:0] r_frame_cnt;
  logic [ERR_W-1:0]   r_err;

  logic [CNT_W:0]     w_since_inc;
  logic [CNT_W:0]     w_period_sum;
  logic [CNT_W-1:0]   w_period;
  logic [CNT_W-1:0]   w_since_d;
  logic               w_period_upd;
  logic               w_period_bad;
  logic [ROW_W-1:0]   w_row_base;
  logic [ROW_W-1:0]   w_row_d;
  logic               w_start_d;
  logic               w_rows_bad;
  logic [ERR_W-1:0]   w_err_evt;
  logic [ERR_W-1:0]   w_err_d;

  r2s_edge_detect u_edge_detect (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_des   (i_r2s_des),
    .o_edge  (w_edge),
    .o_p     (w_p),
    .o_multi (w_multi)
  );

  always_comb begin
    w_since_inc  = {1'b0, r_since} + (CNT_W + 1)'(TICKS_PER_CYCLE);
    w_period_sum = {1'b0, r_since} + (CNT_W + 1)'(w_p);
    w_period     = w_period_sum[CNT_W] ? CNT_MAX : w_period_sum[CNT_W-1:0];

    // After an edge at sample p, 4-p ticks of the current window lie beyond it.
    if (w_edge) begin
      w_since_d = CNT_W'(TICKS_PER_CYCLE) - CNT_W'(w_p);
    end else begin
      w_since_d = w_since_inc[CNT_W] ? CNT_MAX : w_since_inc[CNT_W-1:0];
    end

    w_period_upd = w_edge & r_armed;
    w_period_bad = w_period_upd & ((w_period < i_period_min) || (w_period > i_period_max));

    // A coincident frame strobe makes this cycle's edge row 0 of the new frame.
    w_row_base = i_fsync_strobe ? '0 : r_row_cnt;
    w_row_d    = w_row_base;
    if (w_edge && (w_row_base != ROW_MAX)) begin
      w_row_d = w_row_base + ROW_W'(1);
    end
    w_start_d = w_edge & i_trig_en & (w_row_base == i_trig_row);

    w_rows_bad = i_fsync_strobe & r_fsync_seen & (r_row_cnt != i_exp_rows);

    w_err_evt                 = '0;
    w_err_evt[ERR_PERIOD_BIT] = w_period_bad;
    w_err_evt[ERR_ROWS_BIT]   = w_rows_bad;
    w_err_evt[ERR_GLITCH_BIT] = w_multi;
    w_err_d = (r_err & ~{ERR_W{i_clear_err}}) | w_err_evt;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_since        <= '0;
      r_armed        <= 1'b0;
      r_fsync_seen   <= 1'b0;
      r_start        <= 1'b0;
      r_period_last  <= '0;
      r_period_valid <= 1'b0;
      r_row_cnt      <= '0;
      r_rows_last    <= '0;
      r_frame_cnt    <= '0;
      r_err          <= '0;
    end else begin
      r_since        <= w_since_d;
      r_armed        <= r_armed | w_edge;
      r_start        <= w_start_d;
      r_period_valid <= w_period_upd;
      r_row_cnt      <= w_row_d;
      r_err          <= w_err_d;
      if (w_period_upd) begin
        r_period_last <= w_period;
      end
      if (i_fsync_strobe) begin
        r_rows_last  <= r_row_cnt;
        r_frame_cnt  <= r_frame_cnt + FRAME_W'(1);
        r_fsync_seen <= 1'b1;
      end
    end
  end

  always_comb begin
    o_start           = r_start;
    o_period_last     = r_period_last;
    o_period_valid    = r_period_valid;
    o_row_cnt         = r_row_cnt;
    o_rows_last_frame = r_rows_last;
    o_frame_cnt       = r_frame_cnt;
    o_err_period      = r_err[ERR_PERIOD_BIT];
    o_err_rows        = r_err[ERR_ROWS_BIT];
    o_err_glitch      = r_err[ERR_GLITCH_BIT];
  end

endmodule

// File: tb/tb_r2s_frame_monitor.sv
// Bench for r2s_frame_monitor: directed scenarios plus a randomized run against a
// timestamp-based reference model.
module tb_r2s_frame_monitor;

  localparam int unsigned CNT_W   = 16;
  localparam int unsigned ROW_W   = 10;
  localparam int unsigned FRAME_W = 16;
  localparam longint      CNT_SAT = 65535;
  localparam int          ROW_SAT = 1023;

  logic               clk = 1'b0;
  logic               rst_n = 1'b1;
  logic [3:0]         des = '0;
  logic               fsync = 1'b0;
  logic [ROW_W-1:0]   exp_rows = '0;
  logic [CNT_W-1:0]   pmin = '0;
  logic [CNT_W-1:0]   pmax = '1;
  logic [ROW_W-1:0]   trig_row = '0;
  logic               trig_en = 1'b0;
  logic               clear_err = 1'b0;
  logic               o_start;
  logic [CNT_W-1:0]   o_period_last;
  logic               o_period_valid;
  logic [ROW_W-1:0]   o_row_cnt;
  logic [ROW_W-1:0]   o_rows_last_frame;
  logic [FRAME_W-1:0] o_frame_cnt;
  logic               o_err_period;
  logic               o_err_rows;
  logic               o_err_glitch;

  always #5 clk = ~clk;

  r2s_frame_monitor #(
    .CNT_W   (CNT_W),
    .ROW_W   (ROW_W),
    .FRAME_W (FRAME_W)
  ) dut (
    .i_clk             (clk),
    .i_rst_n           (rst_n),
    .i_r2s_des         (des),
    .i_fsync_strobe    (fsync),
    .i_exp_rows        (exp_rows),
    .i_period_min      (pmin),
    .i_period_max      (pmax),
    .i_trig_row        (trig_row),
    .i_trig_en         (trig_en),
    .i_clear_err       (clear_err),
    .o_start           (o_start),
    .o_period_last     (o_period_last),
    .o_period_valid    (o_period_valid),
    .o_row_cnt         (o_row_cnt),
    .o_rows_last_frame (o_rows_last_frame),
    .o_frame_cnt       (o_frame_cnt),
    .o_err_period      (o_err_period),
    .o_err_rows        (o_err_rows),
    .o_err_glitch      (o_err_glitch)
  );

  int total = 0;
  int bad   = 0;

  // Reference model: absolute 320 MHz tick timestamps of every rising edge.
  longint m_tick = 0;
  longint m_last_edge = -1;
  bit     m_prev = 1'b0;
  int     m_rows = 0;
  bit     m_fsync_seen = 1'b0;
  bit     e_start, e_pvalid, e_err_p, e_err_r, e_err_g;
  int     e_plast, e_rows_last, e_frame;
  int     last_n, last_p;

  task automatic model_reset();
    m_last_edge  = -1;
    m_prev       = 1'b0;
    m_rows       = 0;
    m_fsync_seen = 1'b0;
    {e_start, e_pvalid, e_err_p, e_err_r, e_err_g} = '0;
    e_plast = 0; e_rows_last = 0; e_frame = 0;
  endtask

  task automatic model_step(input logic [3:0] d, input bit fs, input bit clr);
    int n = 0;
    int p = 0;
    bit prv = m_prev;
    longint per;
    int base;
    for (int i = 0; i < 4; i++) begin
      if (d[i] && !prv) begin
        if (n == 0) p = i;
        n++;
      end
      prv = d[i];
    end
    e_pvalid = 1'b0;
    if (clr) {e_err_p, e_err_r, e_err_g} = '0;
    if (n > 1) e_err_g = 1'b1;
    if (n > 0) begin
      if (m_last_edge >= 0) begin
        per = m_tick + p - m_last_edge;
        if (per > CNT_SAT) per = CNT_SAT;
        e_plast  = int'(per);
        e_pvalid = 1'b1;
        if (per < longint'(pmin) || per > longint'(pmax)) e_err_p = 1'b1;
      end
      m_last_edge = m_tick + p;
    end
    base    = fs ? 0 : m_rows;
    e_start = (n > 0) && trig_en && (base == int'(trig_row));
    if (fs) begin
      e_rows_last = m_rows;
      if (m_fsync_seen && m_rows != int'(exp_rows)) e_err_r = 1'b1;
      m_fsync_seen = 1'b1;
      e_frame = (e_frame + 1) % 65536;
    end
    m_rows = base + ((n > 0 && base < ROW_SAT) ? 1 : 0);
    m_prev = d[3];
    m_tick += 4;
    last_n = n;
    last_p = p;
  endtask

  task automatic cycle(input logic [3:0] d, input bit fs, input bit clr);
    des = d; fsync = fs; clear_err = clr;
    @(posedge clk);
    model_step(d, fs, clr);
    #1;
  endtask

  task automatic do_reset();
    rst_n = 1'b0; des = '0; fsync = 1'b0; clear_err = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_reset();
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_start, o_period_valid, o_err_period, o_err_rows, o_err_glitch} !== 5'b0) begin
      bad++;
      $display("FAIL reset_flags got=%b want=00000",
               {o_start, o_period_valid, o_err_period, o_err_rows, o_err_glitch});
    end
    total++;
    if ({o_period_last, o_row_cnt, o_rows_last_frame, o_frame_cnt} !== '0) begin
      bad++;
      $display("FAIL reset_counters got plast=%0d row=%0d rlast=%0d frame=%0d want all 0",
               o_period_last, o_row_cnt, o_rows_last_frame, o_frame_cnt);
    end
    @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic test_steady();
    longint off;
    int     w, edges, valids;
    logic [3:0] d;
    pmin = 16'd70; pmax = 16'd80;
    off = m_tick + $urandom_range(0, 76);
    w = $urandom_range(1, 60);
    edges = 0; valids = 0;
    for (int c = 0; c < 200; c++) begin
      for (int i = 0; i < 4; i++) begin
        d[i] = (m_tick + i >= off) && (((m_tick + i - off) % 77) < w);
      end
      cycle(d, 1'b0, 1'b0);
      edges += last_n;
      if (o_period_valid) valids++;
      total++;
      if (o_period_valid !== e_pvalid) begin
        bad++;
        $display("FAIL steady_valid c=%0d got=%b want=%b", c, o_period_valid, e_pvalid);
      end
      if (e_pvalid) begin
        total++;
        if (o_period_last !== 16'd77) begin
          bad++;
          $display("FAIL steady_period c=%0d got=%0d want=77", c, o_period_last);
        end
      end
    end
    total++;
    if (valids != edges - 1 || edges < 5) begin
      bad++;
      $display("FAIL steady_count valids=%0d want=%0d (edges-1)", valids, edges - 1);
    end
    total++;
    if ({o_err_period, o_err_rows, o_err_glitch} !== 3'b000) begin
      bad++;
      $display("FAIL steady_errs got=%b want=000", {o_err_period, o_err_rows, o_err_glitch});
    end
  endtask

  task automatic test_period17();
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b1000, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b0, 1'b0);
    total++;
    if (o_period_valid !== 1'b1 || o_period_last !== 16'd17) begin
      bad++;
      $display("FAIL period17 got valid=%b period=%0d want valid=1 period=17",
               o_period_valid, o_period_last);
    end
  endtask

  task automatic test_frames();
    int rows [4] = '{3, 8, 8, 7};
    bit errw [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    int p;
    do_reset();
    pmin = '0; pmax = '1; exp_rows = 10'd8; trig_en = 1'b0;
    for (int f = 0; f < 4; f++) begin
      for (int r = 0; r < rows[f]; r++) begin
        p = $urandom_range(0, 3);
        cycle(4'b1111 << p, 1'b0, 1'b0);
        repeat ($urandom_range(1, 3)) cycle(4'b0000, 1'b0, 1'b0);
      end
      cycle(4'b0000, 1'b1, 1'b0);
      total++;
      if (o_err_rows !== errw[f] || o_rows_last_frame !== 10'(rows[f])) begin
        bad++;
        $display("FAIL frames_%0d got err=%b rlast=%0d want err=%b rlast=%0d",
                 f, o_err_rows, o_rows_last_frame, errw[f], rows[f]);
      end
      total++;
      if (o_frame_cnt !== 16'(f + 1) || o_row_cnt !== 10'd0) begin
        bad++;
        $display("FAIL frames_cnt_%0d got frame=%0d row=%0d want frame=%0d row=0",
                 f, o_frame_cnt, o_row_cnt, f + 1);
      end
    end
  endtask

  task automatic test_trigger();
    int starts;
    do_reset();
    trig_row = 10'd3; trig_en = 1'b1; exp_rows = 10'd6;
    for (int f = 0; f < 3; f++) begin
      starts = 0;
      cycle(4'b0000, 1'b1, 1'b0);
      for (int r = 0; r < 6; r++) begin
        cycle(4'b1111 << $urandom_range(0, 3), 1'b0, 1'b0);
        if (o_start) starts++;
        total++;
        if (o_start !== (r == 3)) begin
          bad++;
          $display("FAIL trig_row f=%0d r=%0d got=%b want=%b", f, r, o_start, r == 3);
        end
        repeat ($urandom_range(1, 2)) begin
          cycle(4'b0000, 1'b0, 1'b0);
          if (o_start) starts++;
        end
      end
      total++;
      if (starts != 1) begin
        bad++;
        $display("FAIL trig_once f=%0d got=%0d want=1", f, starts);
      end
    end
    trig_row = 10'd0;
    cycle(4'b0000, 1'b0, 1'b0);
    cycle(4'b0001, 1'b1, 1'b0);
    total++;
    if (o_start !== 1'b1 || o_row_cnt !== 10'd1 || o_rows_last_frame !== 10'd6) begin
      bad++;
      $display("FAIL trig_coincident got start=%b row=%0d rlast=%0d want start=1 row=1 rlast=6",
               o_start, o_row_cnt, o_rows_last_frame);
    end
  endtask

  task automatic test_glitch();
    logic [ROW_W-1:0] rc;
    trig_en = 1'b0;
    cycle(4'b0000, 1'b0, 1'b1);
    rc = o_row_cnt;
    cycle(4'b0101, 1'b0, 1'b0);
    total++;
    if (o_err_glitch !== 1'b1 || o_row_cnt !== rc + 10'd1) begin
      bad++;
      $display("FAIL glitch_set got err=%b row=%0d want err=1 row=%0d",
               o_err_glitch, o_row_cnt, rc + 10'd1);
    end
    total++;
    if (o_period_last !== 16'(e_plast)) begin
      bad++;
      $display("FAIL glitch_p0 got period=%0d want=%0d", o_period_last, e_plast);
    end
    cycle(4'b0000, 1'b0, 1'b1);
    total++;
    if (o_err_glitch !== 1'b0) begin
      bad++;
      $display("FAIL glitch_clear got=%b want=0", o_err_glitch);
    end
    cycle(4'b0101, 1'b0, 1'b1);
    total++;
    if (o_err_glitch !== 1'b1) begin
      bad++;
      $display("FAIL glitch_set_wins got=%b want=1", o_err_glitch);
    end
    cycle(4'b0000, 1'b0, 1'b1);
  endtask

  task automatic test_saturate();
    pmin = 16'd70; pmax = 16'd80;
    cycle(4'b0001, 1'b0, 1'b0);
    cycle(4'b0000, 1'b0, 1'b1);
    for (int c = 0; c < 20000; c++) cycle(4'b0000, 1'b0, 1'b0);
    total++;
    if (o_err_period !== 1'b0) begin
      bad++;
      $display("FAIL sat_noedge_err got=%b want=0", o_err_period);
    end
    cycle(4'b0001, 1'b0, 1'b0);
    total++;
    if (o_period_valid !== 1'b1 || o_period_last !== 16'd65535 || o_err_period !== 1'b1) begin
      bad++;
      $display("FAIL sat_period got valid=%b period=%0d err=%b want 1/65535/1",
               o_period_valid, o_period_last, o_err_period);
    end
  endtask

  task automatic test_async_reset();
    trig_en = 1'b1; trig_row = 10'd0;
    for (int r = 0; r < 3; r++) begin
      cycle(4'b0011, 1'b0, 1'b0);
      cycle(4'b0000, 1'b0, 1'b0);
    end
    cycle(4'b0101, 1'b1, 1'b0);
    #2 rst_n = 1'b0;
    #1;
    total++;
    if ({o_start, o_period_valid, o_err_period, o_err_rows, o_err_glitch} !== 5'b0 ||
        {o_period_last, o_row_cnt, o_rows_last_frame, o_frame_cnt} !== '0) begin
      bad++;
      $display("FAIL async_reset got start=%b pv=%b err=%b%b%b row=%0d frame=%0d want all 0",
               o_start, o_period_valid, o_err_period, o_err_rows, o_err_glitch,
               o_row_cnt, o_frame_cnt);
    end
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 3; c++) begin
      cycle(4'b0000, 1'b0, 1'b0);
      total++;
      if (o_start !== 1'b0 || o_period_valid !== 1'b0) begin
        bad++;
        $display("FAIL async_quiet c=%0d got start=%b pv=%b want 0/0", c, o_start, o_period_valid);
      end
    end
    cycle(4'b0001, 1'b0, 1'b0);
    total++;
    if (o_period_valid !== 1'b0 || o_row_cnt !== 10'd1 || o_start !== 1'b1) begin
      bad++;
      $display("FAIL async_first_edge got pv=%b row=%0d start=%b want 0/1/1",
               o_period_valid, o_row_cnt, o_start);
    end
  endtask

  task automatic test_random();
    logic [3:0] d;
    bit fs, clr;
    do_reset();
    pmin = 16'($urandom_range(10, 40));
    pmax = pmin + 16'($urandom_range(0, 40));
    exp_rows = 10'($urandom_range(2, 6));
    trig_row = 10'($urandom_range(0, 5));
    trig_en = 1'b1;
    for (int c = 0; c < 3000; c++) begin
      d   = ($urandom_range(0, 7) < 5) ? 4'b0000 : 4'($urandom_range(0, 15));
      fs  = ($urandom_range(0, 19) == 0);
      clr = ($urandom_range(0, 29) == 0);
      cycle(d, fs, clr);
      total++;
      if (o_start !== e_start || o_period_valid !== e_pvalid) begin
        bad++;
        $display("FAIL rnd_pulses c=%0d got start=%b pv=%b want %b/%b",
                 c, o_start, o_period_valid, e_start, e_pvalid);
      end
      total++;
      if (o_period_last !== 16'(e_plast)) begin
        bad++;
        $display("FAIL rnd_period c=%0d got=%0d want=%0d", c, o_period_last, e_plast);
      end
      total++;
      if (o_row_cnt !== 10'(m_rows) || o_rows_last_frame !== 10'(e_rows_last) ||
          o_frame_cnt !== 16'(e_frame)) begin
        bad++;
        $display("FAIL rnd_rows c=%0d got row=%0d rlast=%0d frame=%0d want %0d/%0d/%0d", c,
                 o_row_cnt, o_rows_last_frame, o_frame_cnt, m_rows, e_rows_last, e_frame);
      end
      total++;
      if ({o_err_period, o_err_rows, o_err_glitch} !== {e_err_p, e_err_r, e_err_g}) begin
        bad++;
        $display("FAIL rnd_errs c=%0d got=%b want=%b", c,
                 {o_err_period, o_err_rows, o_err_glitch}, {e_err_p, e_err_r, e_err_g});
      end
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_period17();
    test_frames();
    test_trigger();
    test_glitch();
    test_saturate();
    test_async_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
